// File: rtl/rv_mem_pkg.sv
// Shared definitions for the unified memory arbiter slice.
// Contents:
//   - default word-address width and fetch starvation limit
//   - RV32I load/store size codes (funct3)
//   - arbiter FSM state encoding
//   - helper that classifies a data access as misaligned or illegal
package rv_mem_pkg;

    localparam int ADDR_W_DEFAULT       = 30;
    localparam int STARVE_LIMIT_DEFAULT = 2;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_IF_RSP = 2'b01,
        ST_D_RSP  = 2'b10
    } arb_state_e;

    // Unsigned sizes have no store form, so BU/HU stores are treated as illegal.
    function automatic logic data_access_err(input logic       we,
                                             input logic [2:0] funct3,
                                             input logic [1:0] lo);
        logic err;
        case (funct3)
            F3_B:    err = 1'b0;
            F3_H:    err = lo[0];
            F3_W:    err = (lo != 2'b00);
            F3_BU:   err = we;
            F3_HU:   err = we | lo[0];
            default: err = 1'b1;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering for the data port.
// Request side (grant cycle):
//   req_we, req_funct3, req_lo, req_wdata -> req_be, req_wdata_lanes, req_err
// Response side (response cycle, using values latched at grant):
//   rsp_funct3, rsp_lo, rsp_word -> rsp_data (selected and extended load data)
module lsu_align
    import rv_mem_pkg::*;
(
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [1:0]  req_lo,
    input  logic [31:0] req_wdata,
    output logic [3:0]  req_be,
    output logic [31:0] req_wdata_lanes,
    output logic        req_err,
    input  logic [2:0]  rsp_funct3,
    input  logic [1:0]  rsp_lo,
    input  logic [31:0] rsp_word,
    output logic [31:0] rsp_data
);

    logic [31:0] rsp_shifted_s;

    // Byte enables and lane replication for the access being granted.
    always_comb begin
        req_err         = data_access_err(req_we, req_funct3, req_lo);
        req_be          = 4'b1111;
        req_wdata_lanes = req_wdata;
        if (req_we) begin
            case (req_funct3)
                F3_B: begin
                    req_be          = 4'b0001 << req_lo;
                    req_wdata_lanes = {4{req_wdata[7:0]}};
                end
                F3_H: begin
                    req_be          = 4'b0011 << req_lo;
                    req_wdata_lanes = {2{req_wdata[15:0]}};
                end
                default: begin
                    req_be          = 4'b1111;
                    req_wdata_lanes = req_wdata;
                end
            endcase
        end else begin
            req_be          = 4'b1111;
            req_wdata_lanes = req_wdata;
        end
    end

    // Move the addressed byte/half to bit 0, then sign- or zero-extend it.
    always_comb begin
        rsp_shifted_s = rsp_word >> {rsp_lo, 3'b000};
        case (rsp_funct3)
            F3_B:    rsp_data = {{24{rsp_shifted_s[7]}}, rsp_shifted_s[7:0]};
            F3_H:    rsp_data = {{16{rsp_shifted_s[15]}}, rsp_shifted_s[15:0]};
            F3_BU:   rsp_data = {24'h000000, rsp_shifted_s[7:0]};
            F3_HU:   rsp_data = {16'h0000, rsp_shifted_s[15:0]};
            default: rsp_data = rsp_word;
        endcase
    end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Arbitrates an instruction-fetch port and a data load/store port onto one
// single-ported word memory with a one-cycle read latency.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   if_req/if_addr                fetch request (held until if_valid)
//   if_valid/if_rdata/if_err      fetch response pulse, word, misalign flag
//   d_req/d_we/d_funct3/d_addr/d_wdata   data request (held until d_valid)
//   d_valid/d_rdata/d_err         data response pulse, extended load, error
//   mem_en/mem_we/mem_be/mem_addr/mem_wdata/mem_rdata   shared memory port
// Data has priority unless fetch has lost STARVE_LIMIT eligible arbitrations
// in a row. A port whose response is returning this cycle cannot be granted,
// so two active requesters alternate at one access per cycle.
module unified_mem_arbiter
    import rv_mem_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEFAULT,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic              if_valid,
    output logic [31:0]       if_rdata,
    output logic              if_err,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [2:0]        d_funct3,
    input  logic [31:0]       d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_valid,
    output logic [31:0]       d_rdata,
    output logic              d_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

    arb_state_e       state_r;
    arb_state_e       state_next_s;
    logic [CNT_W-1:0] starve_r;
    logic             f_elig_s;
    logic             d_elig_s;
    logic             grant_f_s;
    logic             grant_d_s;
    logic             f_err_s;

    // Response-cycle context captured at grant.
    logic             rsp_err_r;
    logic             rsp_we_r;
    logic [2:0]       rsp_f3_r;
    logic [1:0]       rsp_lo_r;

    logic [3:0]       lsu_be_s;
    logic [31:0]      lsu_wdata_s;
    logic             lsu_err_s;
    logic [31:0]      lsu_rdata_s;

    lsu_align u_lsu_align (
        .req_we          (d_we),
        .req_funct3      (d_funct3),
        .req_lo          (d_addr[1:0]),
        .req_wdata       (d_wdata),
        .req_be          (lsu_be_s),
        .req_wdata_lanes (lsu_wdata_s),
        .req_err         (lsu_err_s),
        .rsp_funct3      (rsp_f3_r),
        .rsp_lo          (rsp_lo_r),
        .rsp_word        (mem_rdata),
        .rsp_data        (lsu_rdata_s)
    );

    // FSM state register; the state records which port was granted last cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Arbitration and next state; rst gates grants so the bus is quiet during reset.
    always_comb begin
        f_elig_s  = if_req & ~rst & (state_r != ST_IF_RSP);
        d_elig_s  = d_req  & ~rst & (state_r != ST_D_RSP);
        grant_f_s = 1'b0;
        grant_d_s = 1'b0;
        if (d_elig_s && !(f_elig_s && (starve_r == LIMIT_C))) begin
            grant_d_s = 1'b1;
        end else if (f_elig_s) begin
            grant_f_s = 1'b1;
        end else begin
            grant_f_s = 1'b0;
            grant_d_s = 1'b0;
        end
        if (grant_d_s) begin
            state_next_s = ST_D_RSP;
        end else if (grant_f_s) begin
            state_next_s = ST_IF_RSP;
        end else begin
            state_next_s = ST_IDLE;
        end
    end

    // Memory strobes in the grant cycle and response data in the response cycle.
    always_comb begin
        f_err_s   = (if_addr[1:0] != 2'b00);
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_be    = 4'b0000;
        mem_addr  = {ADDR_W{1'b0}};
        mem_wdata = 32'h0000_0000;
        if (grant_d_s) begin
            mem_addr = d_addr[ADDR_W+1:2];
            if (!lsu_err_s) begin
                mem_en    = 1'b1;
                mem_we    = d_we;
                mem_be    = lsu_be_s;
                mem_wdata = d_we ? lsu_wdata_s : 32'h0000_0000;
            end else begin
                mem_en = 1'b0;
            end
        end else if (grant_f_s) begin
            mem_addr = if_addr[ADDR_W+1:2];
            if (!f_err_s) begin
                mem_en = 1'b1;
                mem_be = 4'b1111;
            end else begin
                mem_en = 1'b0;
            end
        end else begin
            mem_en = 1'b0;
        end

        if_valid = (state_r == ST_IF_RSP);
        if_err   = if_valid & rsp_err_r;
        if_rdata = (if_valid && !rsp_err_r) ? mem_rdata : 32'h0000_0000;
        d_valid  = (state_r == ST_D_RSP);
        d_err    = d_valid & rsp_err_r;
        d_rdata  = (d_valid && !rsp_err_r && !rsp_we_r) ? lsu_rdata_s : 32'h0000_0000;
    end

    // Fetch starvation count: cleared by a fetch grant, bumped when fetch loses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_r <= {CNT_W{1'b0}};
        end else if (grant_f_s) begin
            starve_r <= {CNT_W{1'b0}};
        end else if (grant_d_s && f_elig_s && (starve_r != LIMIT_C)) begin
            starve_r <= starve_r + CNT_W'(1);
        end else begin
            starve_r <= starve_r;
        end
    end

    // Capture size, offset and error at grant for use in the response cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_err_r <= 1'b0;
            rsp_we_r  <= 1'b0;
            rsp_f3_r  <= F3_W;
            rsp_lo_r  <= 2'b00;
        end else if (grant_d_s) begin
            rsp_err_r <= lsu_err_s;
            rsp_we_r  <= d_we;
            rsp_f3_r  <= d_funct3;
            rsp_lo_r  <= d_addr[1:0];
        end else if (grant_f_s) begin
            rsp_err_r <= f_err_s;
            rsp_we_r  <= 1'b0;
            rsp_f3_r  <= F3_W;
            rsp_lo_r  <= if_addr[1:0];
        end else begin
            rsp_err_r <= rsp_err_r;
            rsp_we_r  <= rsp_we_r;
            rsp_f3_r  <= rsp_f3_r;
            rsp_lo_r  <= rsp_lo_r;
        end
    end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Self-checking bench for unified_mem_arbiter: directed scenarios plus a
// randomized phase, all compared against a transaction-level model that
// tracks the last granted port, the fetch starvation count and a reference
// memory image updated from the requested stores.
module tb_unified_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_valid;
    logic [31:0] if_rdata;
    logic        if_err;
    logic        d_req;
    logic        d_we;
    logic [2:0]  d_funct3;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_valid;
    logic [31:0] d_rdata;
    logic        d_err;
    logic        mem_en;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    unified_mem_arbiter #(.ADDR_W(30), .STARVE_LIMIT(2)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_valid(if_valid),
        .if_rdata(if_rdata), .if_err(if_err),
        .d_req(d_req), .d_we(d_we), .d_funct3(d_funct3), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_valid(d_valid), .d_rdata(d_rdata), .d_err(d_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
    } d_op_t;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] ref_mem  [64];
    logic [31:0] phys_mem [64];
    logic [31:0] f_q [$];
    d_op_t       d_q [$];
    bit          f_active, d_active, rand_mode;
    int          m_last;     // 0 none, 1 fetch, 2 data granted last cycle
    int          starve;
    int          r_kind;     // response expected this cycle (same coding)
    logic        r_err;
    logic [31:0] r_data;
    logic        prev_ifv, prev_dv;
    logic [31:0] pending;
    logic [2:0]  ld_list [7] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110};
    logic [2:0]  st_list [4] = '{3'b000, 3'b001, 3'b010, 3'b111};

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic model_err(logic we, logic [2:0] f3, logic [1:0] a);
        case (f3)
            3'b000:  return 1'b0;
            3'b001:  return a[0];
            3'b010:  return a != 2'b00;
            3'b100:  return we;
            3'b101:  return we | a[0];
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] load_value(logic [2:0] f3, logic [1:0] a, logic [31:0] w);
        logic [31:0] s;
        logic [7:0]  b;
        logic [15:0] h;
        s = w >> (8 * a);
        b = s[7:0];
        h = s[15:0];
        case (f3)
            3'b000:  return 32'($signed(b));
            3'b001:  return 32'($signed(h));
            3'b100:  return 32'(b);
            3'b101:  return 32'(h);
            default: return w;
        endcase
    endfunction

    task automatic model_clear();
        f_q.delete();
        d_q.delete();
        f_active = 1'b0;
        d_active = 1'b0;
        if_req   = 1'b0;
        d_req    = 1'b0;
        m_last   = 0;
        starve   = 0;
        r_kind   = 0;
        r_err    = 1'b0;
        r_data   = 32'h0;
        prev_ifv = 1'b0;
        prev_dv  = 1'b0;
    endtask

    // One clock cycle: check at negedge, then advance requesters after posedge.
    task automatic step();
        int          win;
        int          w;
        bit          f_el, d_el, f_done, d_done;
        logic        err, exp_en, exp_we;
        logic [1:0]  a;
        logic [3:0]  exp_be;
        logic [31:0] exp_wd, exp_addr;
        d_op_t       op;
        @(negedge clk);
        check_eq("if_valid", 32'(if_valid), 32'(r_kind == 1));
        check_eq("if_err",   32'(if_err),   32'((r_kind == 1) && r_err));
        check_eq("if_rdata", if_rdata, (r_kind == 1) ? r_data : 32'h0);
        check_eq("d_valid",  32'(d_valid),  32'(r_kind == 2));
        check_eq("d_err",    32'(d_err),    32'((r_kind == 2) && r_err));
        check_eq("d_rdata",  d_rdata, (r_kind == 2) ? r_data : 32'h0);
        check_eq("if_valid_b2b", 32'(prev_ifv & if_valid), 32'h0);
        check_eq("d_valid_b2b",  32'(prev_dv & d_valid),   32'h0);
        prev_ifv = if_valid;
        prev_dv  = d_valid;

        f_el = if_req && (m_last != 1);
        d_el = d_req  && (m_last != 2);
        if (d_el && !(f_el && starve == 2)) win = 2;
        else if (f_el)                      win = 1;
        else                                win = 0;

        err = 1'b0; exp_en = 1'b0; exp_we = 1'b0; exp_be = 4'h0;
        exp_wd = 32'h0; exp_addr = 32'h0; r_data = 32'h0;
        if (win == 1) begin
            a        = if_addr[1:0];
            w        = int'(if_addr[7:2]);
            err      = (a != 2'b00);
            exp_en   = !err;
            exp_be   = err ? 4'h0 : 4'hF;
            exp_addr = if_addr >> 2;
            r_data   = err ? 32'h0 : ref_mem[w];
        end else if (win == 2) begin
            a        = d_addr[1:0];
            w        = int'(d_addr[7:2]);
            err      = model_err(d_we, d_funct3, a);
            exp_en   = !err;
            exp_we   = d_we && !err;
            exp_addr = d_addr >> 2;
            if (!err && !d_we) begin
                exp_be = 4'hF;
                r_data = load_value(d_funct3, a, ref_mem[w]);
            end else if (!err) begin
                case (d_funct3)
                    3'b000: begin
                        exp_be = 4'b0001 << a;
                        exp_wd = {4{d_wdata[7:0]}};
                        ref_mem[w][8*a +: 8] = d_wdata[7:0];
                    end
                    3'b001: begin
                        exp_be = 4'b0011 << a;
                        exp_wd = {2{d_wdata[15:0]}};
                        ref_mem[w][8*a +: 16] = d_wdata[15:0];
                    end
                    default: begin
                        exp_be = 4'hF;
                        exp_wd = d_wdata;
                        ref_mem[w] = d_wdata;
                    end
                endcase
            end
        end
        check_eq("mem_en", 32'(mem_en), 32'(exp_en));
        check_eq("mem_we", 32'(mem_we), 32'(exp_we));
        check_eq("mem_be", 32'(mem_be), 32'(exp_be));
        if (exp_en) check_eq("mem_addr", 32'(mem_addr), exp_addr);
        if (exp_we) check_eq("mem_wdata", mem_wdata, exp_wd);

        // Behave as the memory: respond to whatever the DUT actually drives.
        pending = $urandom;
        if (mem_en) begin
            pending = phys_mem[mem_addr[5:0]];
            if (mem_we) begin
                for (int i = 0; i < 4; i++) begin
                    if (mem_be[i]) phys_mem[mem_addr[5:0]][8*i +: 8] = mem_wdata[8*i +: 8];
                end
            end
        end

        if (win == 1) starve = 0;
        else if (win == 2 && f_el && starve < 2) starve++;
        f_done = (r_kind == 1);
        d_done = (r_kind == 2);
        r_kind = win;
        r_err  = err;
        m_last = win;

        @(posedge clk);
        #1;
        mem_rdata = pending;
        if (f_done) begin f_active = 1'b0; if_req = 1'b0; end
        if (d_done) begin d_active = 1'b0; d_req = 1'b0; end
        if (!f_active) begin
            if (f_q.size() > 0) begin
                if_addr = f_q.pop_front(); if_req = 1'b1; f_active = 1'b1;
            end else if (rand_mode && $urandom_range(0, 2) != 0) begin
                if_addr = 32'($urandom_range(0, 255));
                if ($urandom_range(0, 7) != 0) if_addr[1:0] = 2'b00;
                if_req = 1'b1; f_active = 1'b1;
            end
        end
        if (!d_active) begin
            if (d_q.size() > 0) begin
                op = d_q.pop_front();
                d_we = op.we; d_funct3 = op.f3; d_addr = op.addr; d_wdata = op.wdata;
                d_req = 1'b1; d_active = 1'b1;
            end else if (rand_mode && $urandom_range(0, 2) != 0) begin
                d_we     = $urandom_range(0, 1) == 1;
                d_funct3 = d_we ? st_list[$urandom_range(0, 3)] : ld_list[$urandom_range(0, 6)];
                d_addr   = 32'($urandom_range(0, 255));
                if ($urandom_range(0, 1) == 1) d_addr[1:0] = 2'b00;
                d_wdata  = $urandom;
                d_req = 1'b1; d_active = 1'b1;
            end
        end
    endtask

    task automatic run_until_idle(input int max_cycles);
        bit idle;
        idle = 1'b0;
        for (int n = 0; n < max_cycles && !idle; n++) begin
            step();
            idle = (f_q.size() == 0) && (d_q.size() == 0) && !f_active && !d_active && (r_kind == 0);
        end
        check_eq("drain_idle", 32'(idle), 32'h1);
    endtask

    function automatic d_op_t mk(logic we, logic [2:0] f3, logic [31:0] addr, logic [31:0] wdata);
        d_op_t o;
        o.we = we; o.f3 = f3; o.addr = addr; o.wdata = wdata;
        return o;
    endfunction

    initial begin
        for (int i = 0; i < 64; i++) begin
            ref_mem[i]  = $urandom;
            phys_mem[i] = ref_mem[i];
        end
        ref_mem[2]  = 32'h0040_2103;
        phys_mem[2] = 32'h0040_2103;
        rand_mode = 1'b0;
        model_clear();

        // Reset with both requests asserted: nothing may reach the bus.
        rst = 1'b1; if_req = 1'b1; d_req = 1'b1; if_addr = 32'h0; d_addr = 32'h0;
        d_we = 1'b0; d_funct3 = 3'b010; d_wdata = 32'h0; mem_rdata = 32'h0;
        #12;
        check_eq("rst_mem_en",   32'(mem_en),   32'h0);
        check_eq("rst_mem_we",   32'(mem_we),   32'h0);
        check_eq("rst_mem_be",   32'(mem_be),   32'h0);
        check_eq("rst_if_valid", 32'(if_valid), 32'h0);
        check_eq("rst_d_valid",  32'(d_valid),  32'h0);
        check_eq("rst_if_err",   32'(if_err),   32'h0);
        check_eq("rst_d_err",    32'(d_err),    32'h0);
        check_eq("rst_if_rdata", if_rdata,      32'h0);
        check_eq("rst_d_rdata",  d_rdata,       32'h0);
        model_clear();
        @(posedge clk); #1;
        rst = 1'b0;

        // Aligned fetch of a known instruction word.
        f_q.push_back(32'h0000_0008);
        run_until_idle(20);

        // Byte store, then signed and unsigned byte loads of the same byte.
        d_q.push_back(mk(1'b1, 3'b000, 32'h13, 32'h0000_00AB));
        d_q.push_back(mk(1'b0, 3'b000, 32'h13, 32'h0));
        d_q.push_back(mk(1'b0, 3'b100, 32'h13, 32'h0));
        run_until_idle(30);

        // Misaligned halfword load, misaligned fetch, illegal funct3.
        d_q.push_back(mk(1'b0, 3'b001, 32'h21, 32'h0));
        d_q.push_back(mk(1'b0, 3'b011, 32'h20, 32'h0));
        f_q.push_back(32'h0000_0006);
        run_until_idle(30);

        // Both ports busy back to back: interleaving and starvation handling.
        for (int i = 0; i < 6; i++) begin
            f_q.push_back(32'(i * 4));
            d_q.push_back(mk(i[0], 3'b010, 32'(64 + i * 4), $urandom));
        end
        d_q.push_back(mk(1'b1, 3'b001, 32'h42, 32'h0000_BEEF));
        d_q.push_back(mk(1'b0, 3'b101, 32'h42, 32'h0));
        d_q.push_back(mk(1'b0, 3'b001, 32'h42, 32'h0));
        run_until_idle(60);

        // Randomized traffic.
        rand_mode = 1'b1;
        repeat (800) step();
        rand_mode = 1'b0;
        run_until_idle(40);

        // Reset asserted during a data response cycle.
        d_q.push_back(mk(1'b0, 3'b000, 32'h13, 32'h0));
        for (int n = 0; n < 20 && m_last != 2; n++) step();
        check_eq("rst_test_granted", 32'(m_last), 32'h2);
        rst = 1'b1;
        @(negedge clk);
        check_eq("rst_drsp_d_valid", 32'(d_valid),  32'h0);
        check_eq("rst_drsp_d_rdata", d_rdata,       32'h0);
        check_eq("rst_drsp_d_err",   32'(d_err),    32'h0);
        check_eq("rst_drsp_if_valid", 32'(if_valid), 32'h0);
        check_eq("rst_drsp_mem_en",  32'(mem_en),   32'h0);
        check_eq("rst_drsp_mem_we",  32'(mem_we),   32'h0);
        model_clear();
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (6) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/unified_mem_arbiter.md
UNIFIED_MEM_ARBITER -- requirements
Module: unified_mem_arbiter

Interface
REQ-001 Parameter: ADDR_W, 30, word-address width of the shared memory port; matches the instruction memory word-address width.
REQ-002 Parameter: STARVE_LIMIT, 2, consecutive lost arbitrations after which fetch wins.
REQ-003 Clocking and reset: one clock; reset is asynchronous and active-high.
REQ-004 Ports, one per line: name  direction  width  meaning.
  clk  in  1  clock; all state updates on the rising edge
  rst  in  1  asynchronous active-high reset
  if_req  in  1  fetch request; held with if_addr until if_valid
  if_addr  in  32  fetch byte address
  if_valid  out  1  one-cycle fetch completion pulse
  if_rdata  out  32  instruction word; valid with if_valid, else 0
  if_err  out  1  misaligned fetch flag; valid with if_valid
  d_req  in  1  data request; held with d_we/d_funct3/d_addr/d_wdata until d_valid
  d_we  in  1  1 = store, 0 = load
  d_funct3  in  3  RV32I size/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU
  d_addr  in  32  data byte address
  d_wdata  in  32  store data, right-aligned
  d_valid  out  1  one-cycle data completion pulse; loads and stores
  d_rdata  out  32  extended load data; valid with d_valid, else 0
  d_err  out  1  misaligned or illegal-funct3 flag; valid with d_valid
  mem_en  out  1  memory access strobe
  mem_we  out  1  memory write enable
  mem_be  out  4  byte-lane enables; bit i = byte lane i
  mem_addr  out  ADDR_W  word address (byte address bits 31:2)
  mem_wdata  out  32  lane-replicated store data
  mem_rdata  in  32  read word; valid the cycle after mem_en

Function
REQ-005 FSM states IDLE, IF_RSP, D_RSP: the grant cycle moves to IF_RSP or D_RSP; the response cycle pulses the matching valid and grants again or returns to IDLE.
REQ-006 Eligibility: a requester is eligible when req=1 and its response is not being returned this cycle; no requester is granted twice in consecutive cycles.
REQ-007 Priority: data wins when both are eligible, unless the fetch starvation count equals STARVE_LIMIT, in which case fetch wins.
REQ-008 Starvation count: +1 when fetch is eligible and loses; cleared on a fetch grant; saturates at STARVE_LIMIT.
REQ-009 Latency: grant in cycle N, valid pulse in cycle N+1; alternating requesters sustain one access per cycle.
REQ-010 mem_* outputs are combinational in the grant cycle; mem_en=0, mem_we=0, mem_be=0 in every cycle with no grant.
REQ-011 Fetch: mem_be=1111, mem_we=0; if_rdata=mem_rdata.
REQ-012 Store lanes: B gives be=0001<<a[1:0] with wdata byte replicated ×4; H gives be=0011<<a[1:0] with halfword replicated ×2; W gives be=1111.
REQ-013 Load: mem_be=1111; the byte/half is selected by the latched a[1:0]; B/H sign-extend, BU/HU zero-extend.
REQ-014 Errors: H/HU with a[0]=1, W with a[1:0]≠00, illegal funct3, or fetch with a[1:0]≠00 are granted normally but drive mem_en=0. The valid pulse then carries err=1 and rdata=0.
REQ-015 Stores return d_valid with d_rdata=0.
REQ-016 funct3 and a[1:0] are latched at grant for response-cycle extension.

Reset
REQ-017 rst forces IDLE, starvation count 0, and if_valid=d_valid=if_err=d_err=0, rdata=0 and mem_en=mem_we=0 immediately.
REQ-018 An access outstanding at reset is dropped without a valid pulse; arbitration resumes on the first edge after deassertion.

Structure
REQ-019 Package rv_mem_pkg holds the funct3 codes, the FSM state enum, ADDR_W and STARVE_LIMIT defaults.
REQ-020 Sub-module lsu_align holds the combinational lane steering, byte enables, extension and misalignment detection; the arbiter FSM stays in the top.

Verification
REQ-021 Fetch only, if_addr=0x8, mem word 0x00402103 -> mem_addr=2, be=1111; next cycle if_valid=1, if_rdata=0x00402103.
REQ-022 Both requesting continuously -> grant order D,F,D,F...; neither valid is ever high in two consecutive cycles for the same port.
REQ-023 sb d_addr=0x13, d_wdata=0xAB -> mem_addr=4, be=1000, wdata=0xABABABAB; then lb 0x13 returns 0xFFFFFFAB, lbu returns 0x000000AB.
REQ-024 lh d_addr=0x21 -> mem_en=0; next cycle d_valid=1, d_err=1, d_rdata=0.
REQ-025 Data held and fetch eligible 3 arbitrations, STARVE_LIMIT=2 -> fetch granted on the 3rd, count returns to 0.
REQ-026 rst asserted in D_RSP -> d_valid stays 0, outputs zero that cycle; after release an idle bus shows no spurious pulses.
